stream_pkt_xbar: RTL and testbench
==================================

Name: stream_pkt_xbar

Overview:
- Fully connected, packet-aware stream crossbar with NumInp inputs and NumOut outputs.
- Each output grants one input at a time and holds that grant until the input's `last` beat, so packets are never interleaved on an output.
- The output port is selected on the first beat of a packet and held for the whole packet.
- Optional per-output FIFO buffering. Sits between multi-beat stream producers (DMA, packet engines) and consumers.

Parameters:
- NumInp, 1: number of inputs (>0).
- NumOut, 1: number of outputs (>0).
- DataWidth, 32: payload width in bits.
- FifoDepth, 2: per-output buffer depth in entries; 0 = no buffer, combinational pass-through.
- SelWidth, derived = max(1, clog2(NumOut)); do not override.
- IdxWidth, derived = max(1, clog2(NumInp)); do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- clr_i  in  1  synchronous clear, active high.
- data_i  in  NumInp*DataWidth  input payloads.
- sel_i  in  NumInp*SelWidth  output select; sampled on the first beat of a packet only.
- last_i  in  NumInp  marks the final beat of a packet.
- valid_i  in  NumInp  input valid.
- ready_o  out  NumInp  input ready.
- data_o  out  NumOut*DataWidth  output payloads.
- idx_o  out  NumOut*IdxWidth  source input index of the beat.
- last_o  out  NumOut  final beat of a packet.
- valid_o  out  NumOut  output valid.
- ready_i  in  NumOut  output ready.

Behaviour:
- Handshake: a beat transfers when valid && ready on the same rising edge.
- Inputs: once valid is asserted, data, sel and last must stay stable until ready.
- Outputs: once valid_o is asserted, data_o, idx_o and last_o are held stable until ready_i.
- Input route register, per input:
  - State: in_pkt (1 bit) and route (SelWidth bits).
  - Effective select = in_pkt ? route : sel_i.
  - A handshake with last_i=0 while in_pkt=0 sets in_pkt=1 and latches route = sel_i.
  - A handshake with last_i=1 clears in_pkt.
  - Single-beat packets (last_i=1 on the first beat) never set in_pkt.
- Out-of-range select (effective select >= NumOut): the beat is consumed with ready_o=1 and discarded. The route still latches, so the rest of the packet is discarded the same way.
- Output arbiter, per output j, two states, IDLE and BUSY:
  - Registers: owner (IdxWidth bits) and rr_ptr (IdxWidth bits).
  - IDLE: requesters are inputs with valid_i=1 whose effective select = j. The winner is the first requester at or after rr_ptr, searching upward modulo NumInp. The winner's beat is presented the same cycle (0-cycle arbitration).
  - IDLE with a request, and the beat is not (accepted && last): go to BUSY with owner = winner. This locks in the grant across stalls, so a beat that is presented but not accepted is never withdrawn.
  - IDLE with a request, and a single-beat packet is accepted: stay IDLE; rr_ptr = winner+1 mod NumInp.
  - BUSY: only the owner is connected to the output; all other inputs targeting j see ready_o=0.
  - BUSY, owner's last beat accepted: go to IDLE; rr_ptr = owner+1 mod NumInp.
- Output FIFO, per output, when FifoDepth > 0:
  - Stores {data, idx, last}; depth FifoDepth.
  - Arbiter-side ready = !full.
  - valid_o = !empty. Minimum input-to-output latency is 1 cycle.
  - A push and a pop on the same cycle when full is not allowed (ready = !full); a simultaneous push and pop when not full keeps the count unchanged.
  - Read and write pointers wrap modulo FifoDepth.
- FifoDepth = 0: the arbiter drives the outputs directly; ready_i flows combinationally to ready_o.
- ready_o[i] = 1 when input i is granted by its target output and that output is ready, or when input i is being discarded; 0 otherwise.
- Reset (rst_ni=0) puts the block in this state:
  - all arbiters IDLE; owner=0, rr_ptr=0;
  - in_pkt=0, route=0;
  - FIFOs empty;
  - valid_o=0; data_o, idx_o and last_o = 0.
- Reset mid-packet aborts the packet; the downstream sees a truncated packet.
- clr_i=1: same state as reset on the next edge. All handshakes in that cycle are ignored: no state updates, and no counter increments.
- Simultaneous events: different outputs arbitrate independently, so the same cycle may carry NumOut transfers.

Optional Feature:
- Macro: STREAM_PKT_XBAR_STATS_EN.
- When defined:
  - Adds output port pkt_cnt_o, NumOut*16 bits.
  - Per-output counter increments on every output handshake with last_o=1.
  - Wraps from 0xFFFF to 0.
  - Reset and clr_i set it to 0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- FifoDepth=0, NumInp=2, NumOut=2; input 0 sends 3 beats (A0,A1,A2 with last) to output 1; ready_i[1]=1 throughout -> data_o[1] shows A0,A1,A2 on consecutive cycles, idx_o[1]=0, last_o[1]=1 only on A2.
- Inputs 0 and 1 both send 2-beat packets to output 0 on the same cycle with rr_ptr=0 -> output 0 carries the full input-0 packet, then the full input-1 packet, with no interleaving; after the first packet rr_ptr=1, after the second rr_ptr=0.
- Stall: ready_i[0]=0 for 5 cycles while beat B0 is presented -> valid_o, data_o, idx_o and last_o are stable all 5 cycles; the grant is not reassigned even if a new input starts requesting.
- Route lock: sel_i=1 on the first beat, then sel_i changed to 0 on the second beat -> the second beat still exits output 1; after last, a new packet with sel_i=0 exits output 0.
- FifoDepth=2, ready_i=0: 3 single-beat packets offered -> 2 accepted, third sees ready_o=0; after one pop, the third is accepted the next cycle. NumOut=3, sel_i=3 -> packet consumed, nothing appears on any output.
- STREAM_PKT_XBAR_STATS_EN defined: 4 packets to output 0, then clr_i pulse, then 1 more packet -> pkt_cnt_o[0] reads 4, then 0, then 1.

Source files
------------

// File: rtl/stream_pkt_xbar.sv
// Packet-aware NumInp x NumOut stream crossbar with per-output round-robin grant lock and optional output FIFOs.
// Optional per-output packet counters are enabled with `define STREAM_PKT_XBAR_STATS_EN.

module stream_pkt_xbar_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    // Empty reads as zero so the output bus is clean after reset and between packets.
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        push  = push_i && !full_o && !clr_i;
        pop   = pop_i && !empty_o && !clr_i;
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = wdata_i;
            wr_d        = ptr_inc(wr_q);
        end
        if (pop) rd_d = ptr_inc(rd_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module stream_pkt_xbar #(
    parameter int unsigned NumInp    = 1,
    parameter int unsigned NumOut    = 1,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned SelWidth  = (NumOut > 1) ? $clog2(NumOut) : 1,
    parameter int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic [NumInp*DataWidth-1:0]   data_i,
    input  logic [NumInp*SelWidth-1:0]    sel_i,
    input  logic [NumInp-1:0]             last_i,
    input  logic [NumInp-1:0]             valid_i,
    output logic [NumInp-1:0]             ready_o,
    output logic [NumOut*DataWidth-1:0]   data_o,
    output logic [NumOut*IdxWidth-1:0]    idx_o,
    output logic [NumOut-1:0]             last_o,
    output logic [NumOut-1:0]             valid_o,
    input  logic [NumOut-1:0]             ready_i
`ifdef STREAM_PKT_XBAR_STATS_EN
    ,
    output logic [NumOut*16-1:0]          pkt_cnt_o
`endif
);
    localparam int unsigned EntW = DataWidth + IdxWidth + 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} arb_state_e;

    logic [SelWidth-1:0] eff_sel [NumInp];
    logic [NumInp-1:0]   discard, hs;
    logic [NumInp-1:0]   in_pkt_q, in_pkt_d;
    logic [SelWidth-1:0] route_q [NumInp];
    logic [SelWidth-1:0] route_d [NumInp];

    arb_state_e          state_q [NumOut];
    arb_state_e          state_d [NumOut];
    logic [IdxWidth-1:0] owner_q [NumOut];
    logic [IdxWidth-1:0] owner_d [NumOut];
    logic [IdxWidth-1:0] rr_q    [NumOut];
    logic [IdxWidth-1:0] rr_d    [NumOut];

    logic [NumOut-1:0]   arb_vld, arb_rdy, arb_last;
    logic [IdxWidth-1:0] arb_gnt [NumOut];
    logic [IdxWidth-1:0] arb_win [NumOut];
    logic [EntW-1:0]     arb_ent [NumOut];

    function automatic logic [IdxWidth-1:0] idx_inc(input logic [IdxWidth-1:0] x);
        return IdxWidth'((int'(x) + 1) % int'(NumInp));
    endfunction

    // Request matrix and per-output round-robin pick; BUSY outputs only listen to their owner.
    always_comb begin
        logic [NumInp-1:0]   req;
        logic [IdxWidth-1:0] cand;
        logic                win_vld;
        for (int i = 0; i < NumInp; i++) begin
            eff_sel[i] = in_pkt_q[i] ? route_q[i] : sel_i[i*SelWidth +: SelWidth];
            discard[i] = int'(eff_sel[i]) >= int'(NumOut);
        end
        for (int j = 0; j < NumOut; j++) begin
            req = '0;
            for (int i = 0; i < NumInp; i++)
                req[i] = valid_i[i] && !discard[i] && (int'(eff_sel[i]) == j);
            arb_win[j] = '0;
            win_vld    = 1'b0;
            for (int k = NumInp - 1; k >= 0; k--) begin
                cand = IdxWidth'((int'(rr_q[j]) + k) % int'(NumInp));
                if (req[cand]) begin
                    arb_win[j] = cand;
                    win_vld    = 1'b1;
                end
            end
            if (state_q[j] == ST_BUSY) begin
                arb_gnt[j] = owner_q[j];
                arb_vld[j] = req[owner_q[j]];
            end else begin
                arb_gnt[j] = arb_win[j];
                arb_vld[j] = win_vld;
            end
            arb_last[j] = last_i[arb_gnt[j]];
            arb_ent[j]  = {data_i[int'(arb_gnt[j])*DataWidth +: DataWidth], arb_gnt[j], arb_last[j]};
        end
    end

    always_comb begin
        ready_o = discard;
        for (int j = 0; j < NumOut; j++)
            for (int i = 0; i < NumInp; i++)
                if (arb_vld[j] && arb_rdy[j] && (int'(arb_gnt[j]) == i)) ready_o[i] = 1'b1;
        hs = valid_i & ready_o;
    end

    always_comb begin
        in_pkt_d = in_pkt_q;
        route_d  = route_q;
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        for (int i = 0; i < NumInp; i++) begin
            if (hs[i]) begin
                if (last_i[i]) begin
                    in_pkt_d[i] = 1'b0;
                end else if (!in_pkt_q[i]) begin
                    in_pkt_d[i] = 1'b1;
                    route_d[i]  = sel_i[i*SelWidth +: SelWidth];
                end
            end
        end
        for (int j = 0; j < NumOut; j++) begin
            case (state_q[j])
                ST_IDLE: begin
                    if (arb_vld[j]) begin
                        if (arb_rdy[j] && arb_last[j]) begin
                            rr_d[j] = idx_inc(arb_win[j]);
                        end else begin
                            // Lock the grant so a presented beat is never withdrawn under stall.
                            state_d[j] = ST_BUSY;
                            owner_d[j] = arb_win[j];
                        end
                    end
                end
                ST_BUSY: begin
                    if (arb_vld[j] && arb_rdy[j] && arb_last[j]) begin
                        state_d[j] = ST_IDLE;
                        rr_d[j]    = idx_inc(owner_q[j]);
                    end
                end
                default: state_d[j] = ST_IDLE;
            endcase
        end
        if (clr_i) begin
            in_pkt_d = '0;
            route_d  = '{default: '0};
            state_d  = '{default: ST_IDLE};
            owner_d  = '{default: '0};
            rr_d     = '{default: '0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_pkt_q <= '0;
            route_q  <= '{default: '0};
            state_q  <= '{default: ST_IDLE};
            owner_q  <= '{default: '0};
            rr_q     <= '{default: '0};
        end else begin
            in_pkt_q <= in_pkt_d;
            route_q  <= route_d;
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
        end
    end

    if (FifoDepth > 0) begin : g_fifo
        logic [NumOut-1:0] full, empty;
        logic [EntW-1:0]   rdata [NumOut];

        for (genvar j = 0; j < NumOut; j++) begin : g_out
            stream_pkt_xbar_fifo #(
                .Depth (FifoDepth),
                .Width (EntW)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .clr_i   (clr_i),
                .push_i  (arb_vld[j]),
                .wdata_i (arb_ent[j]),
                .full_o  (full[j]),
                .pop_i   (ready_i[j]),
                .rdata_o (rdata[j]),
                .empty_o (empty[j])
            );
        end

        always_comb begin
            arb_rdy = ~full;
            valid_o = ~empty;
            for (int j = 0; j < NumOut; j++) begin
                data_o[j*DataWidth +: DataWidth] = rdata[j][EntW-1 -: DataWidth];
                idx_o[j*IdxWidth +: IdxWidth]    = rdata[j][IdxWidth:1];
                last_o[j]                        = rdata[j][0];
            end
        end
    end else begin : g_direct
        always_comb begin
            arb_rdy = ready_i;
            valid_o = arb_vld;
            for (int j = 0; j < NumOut; j++) begin
                data_o[j*DataWidth +: DataWidth] = arb_vld[j] ? arb_ent[j][EntW-1 -: DataWidth] : '0;
                idx_o[j*IdxWidth +: IdxWidth]    = arb_vld[j] ? arb_ent[j][IdxWidth:1] : '0;
                last_o[j]                        = arb_vld[j] && arb_ent[j][0];
            end
        end
    end

`ifdef STREAM_PKT_XBAR_STATS_EN
    logic [15:0] pkt_cnt_q [NumOut];
    logic [15:0] pkt_cnt_d [NumOut];

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        for (int j = 0; j < NumOut; j++)
            if (valid_o[j] && ready_i[j] && last_o[j]) pkt_cnt_d[j] = pkt_cnt_q[j] + 16'd1;
        if (clr_i) pkt_cnt_d = '{default: '0};
        for (int j = 0; j < NumOut; j++) pkt_cnt_o[j*16 +: 16] = pkt_cnt_q[j];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pkt_cnt_q <= '{default: '0};
        else         pkt_cnt_q <= pkt_cnt_d;
    end
`endif
endmodule

// File: tb/tb_stream_pkt_xbar.sv
// Directed bench: A = 2x2 pass-through crossbar, B = 2x3 crossbar with 2-deep output FIFOs.
module tb_stream_pkt_xbar;
    logic clk = 1'b0;
    logic rst_n, clr;
    always #5 clk = ~clk;

    logic [31:0] a_data;  logic [1:0] a_sel, a_last, a_valid, a_ready;
    logic [31:0] a_odata; logic [1:0] a_idx, a_olast, a_ovalid, a_oready;
    logic [31:0] b_data;  logic [3:0] b_sel; logic [1:0] b_last, b_valid, b_ready;
    logic [47:0] b_odata; logic [2:0] b_idx, b_olast, b_ovalid, b_oready;
`ifdef STREAM_PKT_XBAR_STATS_EN
    logic [31:0] a_cnt;
    logic [47:0] b_cnt;
`endif

    stream_pkt_xbar #(.NumInp(2), .NumOut(2), .DataWidth(16), .FifoDepth(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .data_i(a_data), .sel_i(a_sel), .last_i(a_last), .valid_i(a_valid), .ready_o(a_ready),
        .data_o(a_odata), .idx_o(a_idx), .last_o(a_olast), .valid_o(a_ovalid), .ready_i(a_oready)
`ifdef STREAM_PKT_XBAR_STATS_EN
        , .pkt_cnt_o(a_cnt)
`endif
    );

    stream_pkt_xbar #(.NumInp(2), .NumOut(3), .DataWidth(16), .FifoDepth(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .data_i(b_data), .sel_i(b_sel), .last_i(b_last), .valid_i(b_valid), .ready_o(b_ready),
        .data_o(b_odata), .idx_o(b_idx), .last_o(b_olast), .valid_o(b_ovalid), .ready_i(b_oready)
`ifdef STREAM_PKT_XBAR_STATS_EN
        , .pkt_cnt_o(b_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input int ln, input logic v, input logic s, input logic [15:0] d, input logic l);
        a_valid[ln] = v; a_sel[ln] = s; a_data[ln*16 +: 16] = d; a_last[ln] = l;
    endtask

    task automatic drv_b(input int ln, input logic v, input logic [1:0] s, input logic [15:0] d, input logic l);
        b_valid[ln] = v; b_sel[ln*2 +: 2] = s; b_data[ln*16 +: 16] = d; b_last[ln] = l;
    endtask

    // {valid, idx, last, data} of one output
    function automatic logic [18:0] a_out(input int j);
        return {a_ovalid[j], a_idx[j], a_olast[j], a_odata[j*16 +: 16]};
    endfunction

    function automatic logic [18:0] b_out(input int j);
        return {b_ovalid[j], b_idx[j], b_olast[j], b_odata[j*16 +: 16]};
    endfunction

    function automatic logic [18:0] E(input logic v, input logic i, input logic l, input logic [15:0] d);
        return {v, i, l, d};
    endfunction

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        a_data = '0; a_sel = '0; a_last = '0; a_valid = '0; a_oready = '0;
        b_data = '0; b_sel = '0; b_last = '0; b_valid = '0; b_oready = '0;
        #2;
        chk("rst_a_out0", a_out(0), E(0, 0, 0, 16'h0));
        chk("rst_a_out1", a_out(1), E(0, 0, 0, 16'h0));
        chk("rst_a_ready", a_ready, 2'b00);
        chk("rst_b_valid", b_ovalid, 3'b000);
        chk("rst_b_data", b_odata, 48'h0);
        step(); step();
        rst_n = 1'b1;
        a_oready = 2'b11;

        // 3-beat packet input 0 -> output 1
        drv_a(0, 1, 1, 16'hA0, 0); #1;
        chk("t1_beat0", a_out(1), E(1, 0, 0, 16'hA0));
        chk("t1_rdy0", a_ready, 2'b01);
        step(); drv_a(0, 1, 1, 16'hA1, 0); #1;
        chk("t1_beat1", a_out(1), E(1, 0, 0, 16'hA1));
        step(); drv_a(0, 1, 1, 16'hA2, 1); #1;
        chk("t1_beat2", a_out(1), E(1, 0, 1, 16'hA2));
        step(); drv_a(0, 0, 0, 16'h0, 0); #1;
        chk("t1_idle", a_ovalid, 2'b00);

        // Two competing 2-beat packets on output 0, no interleave
        drv_a(0, 1, 0, 16'h10, 0); drv_a(1, 1, 0, 16'h20, 0); #1;
        chk("t2_p0b0", a_out(0), E(1, 0, 0, 16'h10));
        chk("t2_rdy_a", a_ready, 2'b01);
        step(); drv_a(0, 1, 0, 16'h11, 1); #1;
        chk("t2_p0b1", a_out(0), E(1, 0, 1, 16'h11));
        chk("t2_rdy_b", a_ready, 2'b01);
        step(); drv_a(0, 0, 0, 16'h0, 0); #1;
        chk("t2_p1b0", a_out(0), E(1, 1, 0, 16'h20));
        chk("t2_rdy_c", a_ready, 2'b10);
        step(); drv_a(1, 1, 0, 16'h21, 1); #1;
        chk("t2_p1b1", a_out(0), E(1, 1, 1, 16'h21));
        // rr_ptr back to 0: both single-beat requests, input 0 wins
        step(); drv_a(0, 1, 0, 16'h30, 1); drv_a(1, 1, 0, 16'h40, 1); #1;
        chk("t2_rr0", a_out(0), E(1, 0, 1, 16'h30));
        chk("t2_rr0_rdy", a_ready, 2'b01);
        // rr_ptr now 1: input 1 wins despite input 0 requesting
        step(); drv_a(0, 1, 0, 16'h31, 1); #1;
        chk("t2_rr1", a_out(0), E(1, 1, 1, 16'h40));
        chk("t2_rr1_rdy", a_ready, 2'b10);
        step(); drv_a(1, 0, 0, 16'h0, 0); #1;
        chk("t2_rr2", a_out(0), E(1, 0, 1, 16'h31));
        step(); drv_a(0, 0, 0, 16'h0, 0);

        // Stall: B0 from input 1 held 5 cycles; input 0 starts requesting mid-stall
        a_oready = 2'b10;
        drv_a(1, 1, 0, 16'h50, 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) drv_a(0, 1, 0, 16'h60, 1);
            #1;
            chk("t3_hold", a_out(0), E(1, 1, 0, 16'h50));
            chk("t3_hold_rdy", a_ready, 2'b00);
            step();
        end
        a_oready = 2'b11; #1;
        chk("t3_release", a_ready, 2'b10);
        step(); drv_a(1, 1, 0, 16'h51, 1); #1;
        chk("t3_b1", a_out(0), E(1, 1, 1, 16'h51));
        chk("t3_b1_rdy", a_ready, 2'b10);
        step(); drv_a(1, 0, 0, 16'h0, 0); #1;
        chk("t3_next", a_out(0), E(1, 0, 1, 16'h60));
        step(); drv_a(0, 0, 0, 16'h0, 0);

        // Route lock: sel changes mid-packet, beat still exits output 1
        drv_a(0, 1, 1, 16'h70, 0); #1;
        chk("t4_b0", a_out(1), E(1, 0, 0, 16'h70));
        step(); drv_a(0, 1, 0, 16'h71, 1); #1;
        chk("t4_b1", a_out(1), E(1, 0, 1, 16'h71));
        chk("t4_b1_out0", a_ovalid[0], 1'b0);
        step(); drv_a(0, 1, 0, 16'h72, 1); #1;
        chk("t4_new", a_out(0), E(1, 0, 1, 16'h72));
        chk("t4_new_out1", a_ovalid[1], 1'b0);
        step(); drv_a(0, 0, 0, 16'h0, 0);

        // FIFO depth 2, output stalled
        drv_b(0, 1, 2'd0, 16'h100, 1); #1;
        chk("t5_acc0", b_ready[0], 1'b1);
        chk("t5_lat", b_ovalid[0], 1'b0);
        step(); drv_b(0, 1, 2'd0, 16'h101, 1); #1;
        chk("t5_acc1", b_ready[0], 1'b1);
        chk("t5_head", b_out(0), E(1, 0, 1, 16'h100));
        step(); drv_b(0, 1, 2'd0, 16'h102, 1); #1;
        chk("t5_full", b_ready[0], 1'b0);
        step();
        chk("t5_full2", b_ready[0], 1'b0);
        b_oready = 3'b001; #1;
        chk("t5_pop_head", b_out(0), E(1, 0, 1, 16'h100));
        chk("t5_full_pop", b_ready[0], 1'b0);
        step(); b_oready = 3'b000; #1;
        chk("t5_acc2", b_ready[0], 1'b1);
        chk("t5_head2", b_out(0), E(1, 0, 1, 16'h101));
        step(); drv_b(0, 0, 2'd0, 16'h0, 0); b_oready = 3'b001; #1;
        chk("t5_drain0", b_out(0), E(1, 0, 1, 16'h101));
        step();
        chk("t5_drain1", b_out(0), E(1, 0, 1, 16'h102));
        step();
        chk("t5_empty", b_ovalid, 3'b000);
        b_oready = 3'b000;

        // Out-of-range select: 2-beat packet discarded
        drv_b(1, 1, 2'd3, 16'h200, 0); #1;
        chk("t6_disc0", b_ready[1], 1'b1);
        step(); drv_b(1, 1, 2'd0, 16'h201, 1); #1;
        chk("t6_disc1", b_ready[1], 1'b1);
        step(); drv_b(1, 1, 2'd2, 16'h202, 1); #1;
        chk("t6_nothing", b_ovalid, 3'b000);
        chk("t6_acc_new", b_ready[1], 1'b1);
        step(); drv_b(1, 0, 2'd0, 16'h0, 0); #1;
        chk("t6_out2", b_out(2), E(1, 1, 1, 16'h202));
        chk("t6_valid", b_ovalid, 3'b100);

`ifdef STREAM_PKT_XBAR_STATS_EN
        clr = 1'b1; step(); clr = 1'b0;
        for (int p = 0; p < 4; p++) begin
            drv_a(0, 1, 0, 16'h80 + 16'(p), 1);
            step();
        end
        drv_a(0, 0, 0, 16'h0, 0); #1;
        chk("t7_cnt4", a_cnt[15:0], 16'd4);
        clr = 1'b1; step(); clr = 1'b0; #1;
        chk("t7_cnt_clr", a_cnt[15:0], 16'd0);
        drv_a(0, 1, 0, 16'h90, 1); step(); drv_a(0, 0, 0, 16'h0, 0); #1;
        chk("t7_cnt1", a_cnt[15:0], 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
